// File: rtl/iob_soc_sut_rst_seq.sv
// -----------------------------------------------------------------------------
// iob_soc_sut_rst_seq
//
// Power-up and reset sequencer for the SUT FPGA top level. It waits for the
// clock generator to lock and, if a DDR controller is present, for its
// calibration to finish. It then releases the Ethernet PHY reset, waits for
// the PHY to settle, and pulses the system reset of the iob_soc_sut instance.
// The whole sequence starts again if lock or calibration is lost, or if a
// restart is requested. If lock or calibration never arrives, the sequencer
// parks in FAULT until a restart is requested.
//
// Parameters:
//   PHY_RST_CYCLES  - cycles the PHY reset is held low (>= 1)
//   PHY_WAIT_CYCLES - cycles from PHY reset release to the system reset pulse (>= 1)
//   SYS_RST_CYCLES  - cycles spent in SYS_RST with the system reset high (>= 1)
//   TIMEOUT_CYCLES  - maximum cycles in WAIT_LOCK / WAIT_CALIB before FAULT (>= 1)
//   CNT_W           - state cycle counter width; every *_CYCLES must be <= 2**CNT_W
//   USE_CALIB       - 1: wait for and monitor calib_done_i, 0: ignore it
//
// Ports:
//   clk_i          in   system clock
//   rstn_i         in   synchronous active-low reset
//   pll_locked_i   in   clock generator locked (synchronous to clk_i)
//   calib_done_i   in   DDR calibration complete (synchronous to clk_i)
//   restart_i      in   single-cycle restart request
//   eth_phy_rstn_o out  Ethernet PHY reset, active-low
//   sys_rst_o      out  system reset, active-high
//   ready_o        out  high only in RUN
//   fault_o        out  high only in FAULT
//   state_o        out  current state encoding
//   restarts_o     out  saturating count of re-sequence events
//
// All outputs are registered. They change only on the rising edge of clk_i.
// -----------------------------------------------------------------------------
module iob_soc_sut_rst_seq #(
  parameter int PHY_RST_CYCLES  = 16,
  parameter int PHY_WAIT_CYCLES = 32,
  parameter int SYS_RST_CYCLES  = 10,
  parameter int TIMEOUT_CYCLES  = 1000000,
  parameter int CNT_W           = 24,
  parameter int USE_CALIB       = 1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       pll_locked_i,
  input  logic       calib_done_i,
  input  logic       restart_i,
  output logic       eth_phy_rstn_o,
  output logic       sys_rst_o,
  output logic       ready_o,
  output logic       fault_o,
  output logic [2:0] state_o,
  output logic [7:0] restarts_o
);

  typedef enum logic [2:0] {
    WAIT_LOCK  = 3'd0,
    WAIT_CALIB = 3'd1,
    PHY_RST    = 3'd2,
    PHY_WAIT   = 3'd3,
    SYS_RST    = 3'd4,
    RUN        = 3'd5,
    FAULT      = 3'd6
  } state_t;

  // Each timed exit fires on the last cycle of its window (count N-1), so the
  // counter is compared against these precomputed terminal values.
  localparam logic [CNT_W-1:0] PHY_RST_LAST  = CNT_W'(PHY_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] PHY_WAIT_LAST = CNT_W'(PHY_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_RST_LAST  = CNT_W'(SYS_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX       = '1;
  localparam bit               CALIB_EN      = (USE_CALIB != 0);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] cnt;
  logic             resequence;
  logic             lock_lost;
  logic             calib_lost;
  logic             calib_ok;

  // Calibration counts as done in builds without DDR, so WAIT_CALIB passes
  // straight through.
  assign calib_ok = calib_done_i || !CALIB_EN;

  // Lock is monitored from WAIT_CALIB onwards. Calibration is monitored only
  // once the sequence has moved past WAIT_CALIB. Losing either one restarts
  // the whole sequence.
  always_comb begin
    lock_lost  = 1'b0;
    calib_lost = 1'b0;
    case (state)
      WAIT_CALIB: begin
        lock_lost = !pll_locked_i;
      end
      PHY_RST, PHY_WAIT, SYS_RST, RUN: begin
        lock_lost  = !pll_locked_i;
        calib_lost = CALIB_EN && !calib_done_i;
      end
      default: begin
        lock_lost  = 1'b0;
        calib_lost = 1'b0;
      end
    endcase
  end

  // Next-state selection in priority order: restart request, loss of lock
  // or calibration, then the per-state progress or timeout decision. In the
  // wait states the normal exit is tested before the timeout. If both occur
  // in the same cycle, the sequence moves forward.
  always_comb begin
    next_state = state;
    resequence = 1'b0;
    if (restart_i) begin
      next_state = WAIT_LOCK;
      resequence = 1'b1;
    end else if (lock_lost || calib_lost) begin
      next_state = WAIT_LOCK;
      resequence = 1'b1;
    end else begin
      case (state)
        WAIT_LOCK: begin
          if (pll_locked_i) begin
            next_state = WAIT_CALIB;
          end else if (cnt == TIMEOUT_LAST) begin
            next_state = FAULT;
          end
        end
        WAIT_CALIB: begin
          if (calib_ok) begin
            next_state = PHY_RST;
          end else if (cnt == TIMEOUT_LAST) begin
            next_state = FAULT;
          end
        end
        PHY_RST: begin
          if (cnt == PHY_RST_LAST) begin
            next_state = PHY_WAIT;
          end
        end
        PHY_WAIT: begin
          if (cnt == PHY_WAIT_LAST) begin
            next_state = SYS_RST;
          end
        end
        SYS_RST: begin
          if (cnt == SYS_RST_LAST) begin
            next_state = RUN;
          end
        end
        RUN: begin
          next_state = RUN;
        end
        FAULT: begin
          next_state = FAULT;
        end
        default: begin
          next_state = WAIT_LOCK;
        end
      endcase
    end
  end

  // State register, cycle counter, restart counter and registered outputs.
  // The outputs are decoded from next_state, so they stay aligned with the
  // state register and need no extra cycle of delay. A re-sequence counts as
  // a state change even when issued from WAIT_LOCK, so the timeout window
  // starts again. In RUN and FAULT the counter stops at its maximum value
  // rather than wrapping.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state          <= WAIT_LOCK;
      cnt            <= '0;
      restarts_o     <= 8'd0;
      eth_phy_rstn_o <= 1'b0;
      sys_rst_o      <= 1'b1;
      ready_o        <= 1'b0;
      fault_o        <= 1'b0;
      state_o        <= 3'd0;
    end else begin
      state <= next_state;

      if (resequence || (next_state != state)) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      if (resequence && (restarts_o != 8'hFF)) begin
        restarts_o <= restarts_o + 8'd1;
      end

      case (next_state)
        PHY_WAIT, SYS_RST: begin
          eth_phy_rstn_o <= 1'b1;
          sys_rst_o      <= 1'b1;
        end
        RUN: begin
          eth_phy_rstn_o <= 1'b1;
          sys_rst_o      <= 1'b0;
        end
        default: begin
          eth_phy_rstn_o <= 1'b0;
          sys_rst_o      <= 1'b1;
        end
      endcase

      ready_o <= (next_state == RUN);
      fault_o <= (next_state == FAULT);
      state_o <= next_state;
    end
  end

endmodule

// File: tb/tb_iob_soc_sut_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_iob_soc_sut_rst_seq
//
// Self-checking bench for iob_soc_sut_rst_seq. Three instances share one set
// of inputs:
//   dut_a - default parameters
//   dut_b - TIMEOUT_CYCLES = 50
//   dut_c - USE_CALIB = 0
// Inputs are driven and outputs sampled on the falling edge of clk.
// -----------------------------------------------------------------------------
module tb_iob_soc_sut_rst_seq;

  logic clk = 1'b0;
  logic rstn, pll_locked, calib_done, restart;

  logic       eth_a, sys_a, rdy_a, flt_a;
  logic [2:0] st_a;
  logic [7:0] rs_a;
  logic       eth_b, sys_b, rdy_b, flt_b;
  logic [2:0] st_b;
  logic [7:0] rs_b;
  logic       eth_c, sys_c, rdy_c, flt_c;
  logic [2:0] st_c;
  logic [7:0] rs_c;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  iob_soc_sut_rst_seq dut_a (
    .clk_i(clk), .rstn_i(rstn), .pll_locked_i(pll_locked), .calib_done_i(calib_done),
    .restart_i(restart), .eth_phy_rstn_o(eth_a), .sys_rst_o(sys_a), .ready_o(rdy_a),
    .fault_o(flt_a), .state_o(st_a), .restarts_o(rs_a)
  );

  iob_soc_sut_rst_seq #(.TIMEOUT_CYCLES(50)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .pll_locked_i(pll_locked), .calib_done_i(calib_done),
    .restart_i(restart), .eth_phy_rstn_o(eth_b), .sys_rst_o(sys_b), .ready_o(rdy_b),
    .fault_o(flt_b), .state_o(st_b), .restarts_o(rs_b)
  );

  iob_soc_sut_rst_seq #(.USE_CALIB(0)) dut_c (
    .clk_i(clk), .rstn_i(rstn), .pll_locked_i(pll_locked), .calib_done_i(calib_done),
    .restart_i(restart), .eth_phy_rstn_o(eth_c), .sys_rst_o(sys_c), .ready_o(rdy_c),
    .fault_o(flt_c), .state_o(st_c), .restarts_o(rs_c)
  );

  // Packed output view: {eth, sys, ready, fault, state[2:0], restarts[7:0]}
  logic [14:0] out_a, out_b, out_c;
  assign out_a = {eth_a, sys_a, rdy_a, flt_a, st_a, rs_a};
  assign out_b = {eth_b, sys_b, rdy_b, flt_b, st_b, rs_b};
  assign out_c = {eth_c, sys_c, rdy_c, flt_c, st_c, rs_c};

  typedef struct {
    string      name;
    logic       rstn;
    logic       locked;
    logic       calib;
    logic       restart;
    int         edges;
    logic [14:0] expected;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] pack(input logic eth, input logic sys, input logic rdy,
                                       input logic flt, input logic [2:0] st,
                                       input logic [7:0] rs);
    return {eth, sys, rdy, flt, st, rs};
  endfunction

  function automatic vec_t mk(input string name, input logic rstn_v, input logic locked_v,
                              input logic calib_v, input logic restart_v, input int edges_v,
                              input logic [14:0] exp_v);
    vec_t v;
    v.name     = name;
    v.rstn     = rstn_v;
    v.locked   = locked_v;
    v.calib    = calib_v;
    v.restart  = restart_v;
    v.edges    = edges_v;
    v.expected = exp_v;
    return v;
  endfunction

  // Drive a set of inputs and let the given number of rising edges pass.
  task automatic apply_stimulus(input logic rstn_v, input logic locked_v, input logic calib_v,
                                input logic restart_v, input int edges_v);
    rstn       = rstn_v;
    pll_locked = locked_v;
    calib_done = calib_v;
    restart    = restart_v;
    repeat (edges_v) @(negedge clk);
  endtask

  task automatic check_output(input string name, input logic [14:0] actual,
                              input logic [14:0] expected);
    checks++;
    if (actual === expected) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got eth/sys/rdy/flt/st/rs=%b/%b/%b/%b/%0d/%0d expected %b/%b/%b/%b/%0d/%0d",
               name, actual[14], actual[13], actual[12], actual[11], actual[10:8], actual[7:0],
               expected[14], expected[13], expected[12], expected[11], expected[10:8],
               expected[7:0]);
    end
  endtask

  initial begin
    // Cumulative edge counts after reset release are noted per row: ready_o
    // rises on edge 60 = 2 + 16 + 32 + 10. The PHY reset is released on edge 18.
    vecs.push_back(mk("reset",          0, 1, 1, 0,   1, pack(0, 1, 0, 0, 3'd0, 8'd0)));
    vecs.push_back(mk("edge1_calib",    1, 1, 1, 0,   1, pack(0, 1, 0, 0, 3'd1, 8'd0)));
    vecs.push_back(mk("edge2_phyrst",   1, 1, 1, 0,   1, pack(0, 1, 0, 0, 3'd2, 8'd0)));
    vecs.push_back(mk("edge17_phyrst",  1, 1, 1, 0,  15, pack(0, 1, 0, 0, 3'd2, 8'd0)));
    vecs.push_back(mk("edge18_phywait", 1, 1, 1, 0,   1, pack(1, 1, 0, 0, 3'd3, 8'd0)));
    vecs.push_back(mk("edge50_sysrst",  1, 1, 1, 0,  32, pack(1, 1, 0, 0, 3'd4, 8'd0)));
    vecs.push_back(mk("edge59_sysrst",  1, 1, 1, 0,   9, pack(1, 1, 0, 0, 3'd4, 8'd0)));
    vecs.push_back(mk("edge60_run",     1, 1, 1, 0,   1, pack(1, 0, 1, 0, 3'd5, 8'd0)));
    vecs.push_back(mk("calib_drop",     1, 1, 0, 0,   1, pack(0, 1, 0, 0, 3'd0, 8'd1)));
    vecs.push_back(mk("reseq_sysrst",   1, 1, 1, 0,  59, pack(1, 1, 0, 0, 3'd4, 8'd1)));
    vecs.push_back(mk("reseq_run",      1, 1, 1, 0,   1, pack(1, 0, 1, 0, 3'd5, 8'd1)));
    vecs.push_back(mk("lock_drop_run",  1, 0, 1, 0,   1, pack(0, 1, 0, 0, 3'd0, 8'd2)));
    vecs.push_back(mk("reset2",         0, 0, 1, 0,   1, pack(0, 1, 0, 0, 3'd0, 8'd0)));
    vecs.push_back(mk("nolock_100",     1, 0, 1, 0, 100, pack(0, 1, 0, 0, 3'd0, 8'd0)));
    vecs.push_back(mk("lock_59",        1, 1, 1, 0,  59, pack(1, 1, 0, 0, 3'd4, 8'd0)));
    vecs.push_back(mk("lock_60_run",    1, 1, 1, 0,   1, pack(1, 0, 1, 0, 3'd5, 8'd0)));
    vecs.push_back(mk("restart_run",    1, 1, 1, 1,   1, pack(0, 1, 0, 0, 3'd0, 8'd1)));
    vecs.push_back(mk("restart_to_run", 1, 1, 1, 0,  60, pack(1, 0, 1, 0, 3'd5, 8'd1)));
    vecs.push_back(mk("restart_run2",   1, 1, 1, 1,   1, pack(0, 1, 0, 0, 3'd0, 8'd2)));
    vecs.push_back(mk("to_phywait",     1, 1, 1, 0,  20, pack(1, 1, 0, 0, 3'd3, 8'd2)));
    vecs.push_back(mk("lock_drop_pw",   1, 0, 1, 0,   1, pack(0, 1, 0, 0, 3'd0, 8'd3)));
    vecs.push_back(mk("nolock_in_wl",   1, 0, 1, 0,   5, pack(0, 1, 0, 0, 3'd0, 8'd3)));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rstn, vecs[i].locked, vecs[i].calib, vecs[i].restart,
                     vecs[i].edges);
      check_output(vecs[i].name, out_a, vecs[i].expected);
    end

    // Timeout (dut_b) and the no-DDR build (dut_c), both with calibration low.
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(1, 1, 0, 0, 50);
    check_output("b_calib_edge50", out_b, pack(0, 1, 0, 0, 3'd1, 8'd0));
    apply_stimulus(1, 1, 0, 0, 1);
    check_output("b_fault_edge51", out_b, pack(0, 1, 0, 1, 3'd6, 8'd0));
    apply_stimulus(1, 1, 0, 0, 8);
    check_output("c_sysrst_edge59", out_c, pack(1, 1, 0, 0, 3'd4, 8'd0));
    apply_stimulus(1, 1, 0, 0, 1);
    check_output("c_run_edge60", out_c, pack(1, 0, 1, 0, 3'd5, 8'd0));
    apply_stimulus(1, 1, 1, 0, 3);
    apply_stimulus(1, 1, 0, 0, 2);
    check_output("c_calib_toggle", out_c, pack(1, 0, 1, 0, 3'd5, 8'd0));
    check_output("b_fault_hold", out_b, pack(0, 1, 0, 1, 3'd6, 8'd0));
    apply_stimulus(1, 1, 0, 1, 1);
    check_output("b_fault_restart", out_b, pack(0, 1, 0, 0, 3'd0, 8'd1));

    // Normal exit and timeout in the same cycle: the exit wins.
    apply_stimulus(0, 1, 0, 0, 1);
    apply_stimulus(1, 1, 0, 0, 50);
    apply_stimulus(1, 1, 1, 0, 1);
    check_output("b_exit_beats_timeout", out_b, pack(0, 1, 0, 0, 3'd2, 8'd0));

    // Restart counter saturation.
    apply_stimulus(0, 1, 1, 0, 1);
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1, 1, 1, 1, 1);
      apply_stimulus(1, 1, 1, 0, 1);
      if (i == 253) check_output("sat_254", out_a, pack(0, 1, 0, 0, 3'd1, 8'd254));
      if (i == 254) check_output("sat_255", out_a, pack(0, 1, 0, 0, 3'd1, 8'd255));
    end
    check_output("sat_300", out_a, pack(0, 1, 0, 0, 3'd1, 8'd255));

    // Reset in the middle of SYS_RST.
    apply_stimulus(1, 1, 1, 1, 1);
    apply_stimulus(1, 1, 1, 0, 54);
    check_output("mid_sysrst", out_a, pack(1, 1, 0, 0, 3'd4, 8'd255));
    apply_stimulus(0, 1, 1, 0, 1);
    check_output("reset_mid_sysrst", out_a, pack(0, 1, 0, 0, 3'd0, 8'd0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
